fc_argmax: RTL and testbench

- Consumer at the output of the final fully-connected layer.
- Captures the 10 signed class scores, which are valid only during the layer's one-cycle finish pulse.
- Scans the scores sequentially to find the maximum.
- Presents the winning class index and score on a valid/ready handshake toward the result/display logic.
- Detects and flags result vectors lost while busy.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/fc_argmax.sv | 104 ++++++++++
 tb/tb_fc_argmax.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants and types.
// Used by the FC-layer argmax consumer.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int N_CLASSES = 10;
  localparam int IDX_W     = 4;

  typedef logic signed [DATA_W-1:0] feature_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } argmax_state_e;

endpackage

// File: rtl/fc_argmax.sv
// Captures FC-layer scores on finish, scans for the maximum,
// and offers class index/score on a valid/ready handshake.
module fc_argmax
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     finish,
  input  feature_t [N_CLASSES:1]   in_feature,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         class_idx,
  output feature_t                 class_score,
  output logic                     busy,
  output logic                     overrun
);

  argmax_state_e    state;
  feature_t         fbuf [N_CLASSES:1];
  feature_t         best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] scan_i;
  feature_t         cand;
  logic             take;
  logic             last;

  always_comb begin
    cand = '0;
    for (int k = 1; k <= N_CLASSES; k++) begin
      if (scan_i == IDX_W'(k)) cand = fbuf[k];
    end
  end

  // Strict compare: on ties the lower index keeps the win.
  assign take = (state == SCAN) && (cand > best);
  assign last = (scan_i == IDX_W'(N_CLASSES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      best        <= '0;
      best_idx    <= '0;
      scan_i      <= '0;
      for (int k = 1; k <= N_CLASSES; k++) begin
        fbuf[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (finish) begin
            for (int k = 1; k <= N_CLASSES; k++) begin
              fbuf[k] <= in_feature[k];
            end
            best     <= in_feature[1];
            best_idx <= IDX_W'(1);
            scan_i   <= IDX_W'(2);
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (finish) overrun <= 1'b1;
          if (take) begin
            best     <= cand;
            best_idx <= scan_i;
          end
          scan_i <= scan_i + 1'b1;
          if (last) begin
            state       <= HOLD;
            out_valid   <= 1'b1;
            class_idx   <= take ? scan_i : best_idx;
            class_score <= take ? cand : best;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (finish) begin
              for (int k = 1; k <= N_CLASSES; k++) begin
                fbuf[k] <= in_feature[k];
              end
              best     <= in_feature[1];
              best_idx <= IDX_W'(1);
              scan_i   <= IDX_W'(2);
              state    <= SCAN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (finish) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax.
// Scores and expected winners are hand-computed per step.
module tb_fc_argmax;
  import cnn_pkg::*;

  typedef int vec_t [10];

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   finish;
  feature_t [N_CLASSES:1] in_feature;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_W-1:0]       class_idx;
  feature_t               class_score;
  logic                   busy;
  logic                   overrun;

  int passed = 0;
  int total  = 0;
  int lat;

  fc_argmax dut (
    .clk         (clk),
    .reset       (reset),
    .finish      (finish),
    .in_feature  (in_feature),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .class_idx   (class_idx),
    .class_score (class_score),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input vec_t s);
    for (int k = 0; k < 10; k++) in_feature[k+1] = feature_t'(s[k]);
    finish = 1'b1;
    step();
    finish = 1'b0;
    in_feature = '0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    finish     = 1'b0;
    out_ready  = 1'b0;
    in_feature = '0;
    step();
    step();
    reset = 1'b0;

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);

    // Basic argmax
    out_ready = 1'b1;
    pulse('{3, -1, 7, 2, 0, 5, -8, 6, 1, 4});
    chk("basic_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("basic_lat", 32'(lat), 32'd9);
    chk("basic_idx", 32'(class_idx), 32'd3);
    chk("basic_score", 32'(class_score), 32'd7);
    step();
    chk("basic_drop", 32'(out_valid), 32'd0);
    chk("basic_idle", 32'(busy), 32'd0);

    // Ties with negatives: lowest index wins
    pulse('{-5, -5, -5, -2, -5, -5, -5, -5, -2, -5});
    wait_valid(lat);
    chk("tie_idx", 32'(class_idx), 32'd4);
    chk("tie_score", 32'(class_score), -32'sd2);
    step();
    pulse('{-32768, -32768, -32768, -32768, -32768,
            -32768, -32768, -32768, -32768, -32768});
    wait_valid(lat);
    chk("min_idx", 32'(class_idx), 32'd1);
    chk("min_score", 32'(class_score), -32'sd32768);
    step();

    // Backpressure
    out_ready = 1'b0;
    pulse('{1, 2, 3, 4, 5, 50, 7, 8, 9, 10});
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd9);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_idx", 32'(class_idx), 32'd6);
      chk("bp_score", 32'(class_score), 32'd50);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_busy", 32'(busy), 32'd0);

    // Overrun during scan
    pulse('{0, 9, 1, 2, 3, 4, 5, 6, 7, 8});
    repeat (3) step();
    chk("ov_pre", 32'(overrun), 32'd0);
    pulse('{0, 0, 0, 0, 0, 0, 0, 0, 0, 100});
    chk("ov_set", 32'(overrun), 32'd1);
    wait_valid(lat);
    chk("ov_idx", 32'(class_idx), 32'd2);
    chk("ov_score", 32'(class_score), 32'd9);
    repeat (12) step();
    chk("ov_no_second", 32'(out_valid), 32'd0);
    chk("ov_sticky", 32'(overrun), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ov_cleared", 32'(overrun), 32'd0);

    // finish coinciding with handshake
    out_ready = 1'b0;
    pulse('{1, 2, 3, 4, 20, 6, 7, 8, 9, 10});
    wait_valid(lat);
    chk("co_first_idx", 32'(class_idx), 32'd5);
    out_ready = 1'b1;
    pulse('{1, 2, 3, 4, 5, 6, 7, 30, 9, 10});
    chk("co_valid", 32'(out_valid), 32'd0);
    chk("co_busy", 32'(busy), 32'd1);
    chk("co_overrun", 32'(overrun), 32'd0);
    wait_valid(lat);
    chk("co_lat", 32'(lat), 32'd9);
    chk("co_idx", 32'(class_idx), 32'd8);
    chk("co_score", 32'(class_score), 32'd30);
    step();
    chk("co_overrun2", 32'(overrun), 32'd0);

    // Reset mid-scan after an overrun
    pulse('{9, 1, 1, 1, 1, 1, 1, 1, 1, 1});
    pulse('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    chk("mr_ov", 32'(overrun), 32'd1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_overrun", 32'(overrun), 32'd0);
    pulse('{1, 2, 3, 4, 5, 6, 77, 8, 9, 10});
    wait_valid(lat);
    chk("mr_lat", 32'(lat), 32'd9);
    chk("mr_idx", 32'(class_idx), 32'd7);
    chk("mr_score", 32'(class_score), 32'd77);
    step();

    // Boundary positions
    pulse('{32767, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    wait_valid(lat);
    chk("b1_idx", 32'(class_idx), 32'd1);
    chk("b1_score", 32'(class_score), 32'd32767);
    step();
    pulse('{3, 11, -4, 0, 5, 10, 2, 9, 11, 12});
    wait_valid(lat);
    chk("b10_idx", 32'(class_idx), 32'd10);
    chk("b10_score", 32'(class_score), 32'd12);
    step();
    chk("b10_done", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
